// File: rtl/bcd_to_binary_transcoder_if.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_transcoder_if
//   Handshake bundle for the BCD-to-binary transcoder.
//   Request side : in (packed BCD, digit 0 in [3:0]), in_valid, in_ready
//   Result side  : out, out_valid, out_ready, overflow, digit_err
//   master modport = the client that supplies BCD and consumes results,
//   slave modport  = the transcoder itself.
// ---------------------------------------------------------------------------
interface bcd_to_binary_transcoder_if #(
    parameter int WIDTH = 16
);
    // Decimal digits in 2^WIDTH-1: floor(WIDTH*log10(2))+1, exact for 2..31
    localparam int IN_DIGITS = (WIDTH * 30103) / 100000 + 1;
    localparam int IN_WIDTH  = 4 * IN_DIGITS;

    logic [IN_WIDTH-1:0] in;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    out;
    logic                out_valid;
    logic                out_ready;
    logic                overflow;
    logic                digit_err;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, overflow, digit_err
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, overflow, digit_err
    );
endinterface

// File: rtl/bcd_to_binary_transcoder.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_transcoder
//   Serial BCD-to-binary converter using reverse double-dabble: WIDTH
//   iterations of "shift {bcd,bin} right, then subtract 3 from every BCD
//   digit that reads >= 8". After WIDTH iterations bin holds value mod
//   2^WIDTH and the residual bcd register holds value >> WIDTH, so any
//   nonzero residue means overflow.
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of bcd_to_binary_transcoder_if (request + result)
// ---------------------------------------------------------------------------
module bcd_to_binary_transcoder #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    bcd_to_binary_transcoder_if.slave     bus
);
    localparam int IN_DIGITS = (WIDTH * 30103) / 100000 + 1;
    localparam int IN_WIDTH  = 4 * IN_DIGITS;
    localparam int CNT_W     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] bcd_q, bcd_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_pend_q, err_pend_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                overflow_q, overflow_d;
    logic                digit_err_q, digit_err_d;

    logic                in_err;
    logic [IN_WIDTH-1:0] bcd_shift;
    logic [IN_WIDTH-1:0] bcd_step;
    logic [WIDTH-1:0]    bin_step;

    // Any nibble above 9 marks the incoming word as malformed BCD
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < IN_DIGITS; i++) begin
            if (bus.in[4*i +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    // One iteration: a digit's bit 3 set after the shift came from the LSB of
    // the digit above, worth 5 here rather than 8, hence the -3 correction
    always_comb begin
        {bcd_shift, bin_step} = {bcd_q, bin_q} >> 1;
        bcd_step = bcd_shift;
        for (int i = 0; i < IN_DIGITS; i++) begin
            if (bcd_shift[4*i + 3]) begin
                bcd_step[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and datapath control; the result registers are written only
    // on the edge that finishes the last iteration
    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        err_pend_d  = err_pend_q;
        out_d       = out_q;
        overflow_d  = overflow_q;
        digit_err_d = digit_err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bcd_d      = bus.in;
                    bin_d      = '0;
                    cnt_d      = '0;
                    err_pend_d = in_err;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                bcd_d = bcd_step;
                bin_d = bin_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    out_d       = err_pend_q ? '0 : bin_step;
                    overflow_d  = !err_pend_q && (|bcd_step);
                    digit_err_d = err_pend_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            err_pend_q  <= 1'b0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            err_pend_q  <= err_pend_d;
            out_q       <= out_d;
            overflow_q  <= overflow_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.overflow  = overflow_q;
    assign bus.digit_err = digit_err_q;
endmodule

// File: tb/tb_bcd_to_binary_transcoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_binary_transcoder
//   Directed bench for the BCD-to-binary transcoder: a WIDTH=16 instance
//   driven with hand-computed vectors (latency, overflow, digit errors,
//   backpressure, mid-conversion reset), plus one instance per WIDTH 2..31
//   converting the largest legal value and the all-nines word.
// ---------------------------------------------------------------------------
module tb_bcd_to_binary_transcoder;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic sweepGo = 1'b0;
    int   sweepDone = 0;

    always #5 clk = ~clk;

    bcd_to_binary_transcoder_if #(.WIDTH(16)) bus ();
    bcd_to_binary_transcoder #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Counts decimal digits of 2^w-1 by repeated division
    function automatic int tbDigits(input int w);
        longint unsigned v;
        int d;
        v = (longint'(1) << w) - 1;
        d = 0;
        while (v > 0) begin
            d++;
            v = v / 10;
        end
        return d;
    endfunction

    // Packs an integer as BCD, digit 0 in the low nibble
    function automatic logic [63:0] toBcd(input longint unsigned v);
        logic [63:0] r;
        longint unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Accepts one word, counts edges to out_valid, checks the result, and
    // optionally holds out_ready low for holdCycles while poking in_valid
    task automatic applyStimulus(input string tag, input logic [19:0] bcd,
                                 input logic [15:0] expOut, input logic expOvf,
                                 input logic expErr, input int holdCycles);
        int n;
        @(negedge clk);
        bus.in       = bcd;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in       = 20'h99999;
        checkOutput({tag, "_busy_ready"}, 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            bus.in_valid = (n == 3);
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, "_latency"}, 64'(n), 64'd16);
        checkOutput({tag, "_out"}, 64'(bus.out), 64'(expOut));
        checkOutput({tag, "_ovf"}, 64'(bus.overflow), 64'(expOvf));
        checkOutput({tag, "_err"}, 64'(bus.digit_err), 64'(expErr));
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 1);
            bus.in       = 20'h00007;
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s_hold%0d_out", tag, i), 64'(bus.out), 64'(expOut));
            checkOutput($sformatf("%s_hold%0d_valid", tag, i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("%s_hold%0d_ready", tag, i), 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
        if (holdCycles > 0) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_after_ready"}, 64'(bus.in_ready), 64'd1);
            checkOutput({tag, "_after_out"}, 64'(bus.out), 64'(expOut));
        end
    endtask

    // One instance per width, each converting 2^W-1 and then all nines
    for (genvar gw = 2; gw <= 31; gw++) begin : g_sweep
        localparam int IW = 4 * tbDigits(gw);
        bcd_to_binary_transcoder_if #(.WIDTH(gw)) sif ();
        bcd_to_binary_transcoder #(.WIDTH(gw)) sdut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (sif)
        );
        initial begin : sweepProc
            logic [63:0] stim;
            logic [63:0] eOut;
            logic        eOvf;
            longint unsigned p;
            int n;
            sif.in        = '0;
            sif.in_valid  = 1'b0;
            sif.out_ready = 1'b0;
            wait (sweepGo);
            for (int c = 0; c < 2; c++) begin
                if (c == 0) begin
                    stim = toBcd((longint'(1) << gw) - 1);
                    eOut = (64'd1 << gw) - 64'd1;
                    eOvf = 1'b0;
                end else begin
                    stim = '0;
                    p = 1;
                    for (int d = 0; d < IW / 4; d++) begin
                        stim[4*d +: 4] = 4'd9;
                        p = p * 10;
                    end
                    eOut = (p - 1) & ((64'd1 << gw) - 64'd1);
                    eOvf = 1'b1;
                end
                @(negedge clk);
                sif.in       = stim[IW-1:0];
                sif.in_valid = 1'b1;
                @(negedge clk);
                sif.in_valid = 1'b0;
                n = 0;
                while (!sif.out_valid && n < gw + 10) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput($sformatf("w%0d_c%0d_valid", gw, c), 64'(sif.out_valid), 64'd1);
                checkOutput($sformatf("w%0d_c%0d_out", gw, c), 64'(sif.out), eOut);
                checkOutput($sformatf("w%0d_c%0d_ovf", gw, c), 64'(sif.overflow), 64'(eOvf));
                sif.out_ready = 1'b1;
                @(negedge clk);
                sif.out_ready = 1'b0;
            end
            sweepDone++;
        end
    end

    initial begin
        int n;
        int sawValid;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out", 64'(bus.out), 64'd0);
        checkOutput("rst_ovf", 64'(bus.overflow), 64'd0);
        checkOutput("rst_err", 64'(bus.digit_err), 64'd0);

        applyStimulus("v12345", 20'h12345, 16'h3039, 1'b0, 1'b0, 0);
        applyStimulus("v09876", 20'h09876, 16'h2694, 1'b0, 1'b0, 5);
        applyStimulus("v00000", 20'h00000, 16'h0000, 1'b0, 1'b0, 0);
        applyStimulus("v65535", 20'h65535, 16'hFFFF, 1'b0, 1'b0, 0);
        applyStimulus("v65536", 20'h65536, 16'h0000, 1'b1, 1'b0, 0);
        applyStimulus("v1A345", 20'h1A345, 16'h0000, 1'b0, 1'b1, 0);
        applyStimulus("v99999", 20'h99999, 16'h869F, 1'b1, 1'b0, 0);

        // Abandon a conversion of 0x12345 after seven iterations
        @(negedge clk);
        bus.in       = 20'h12345;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_out", 64'(bus.out), 64'd0);
        checkOutput("midrst_ovf", 64'(bus.overflow), 64'd0);
        checkOutput("midrst_err", 64'(bus.digit_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sawValid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) sawValid++;
        end
        checkOutput("midrst_no_result", 64'(sawValid), 64'd0);
        applyStimulus("v00042", 20'h00042, 16'h002A, 1'b0, 1'b0, 0);

        sweepGo = 1'b1;
        n = 0;
        while (sweepDone < 30 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sweep_done", 64'(sweepDone), 64'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
